// File: rtl/bcd_step_counter_pkg.sv
// Shared definitions for the BCD step counter slice.
//   state_t   : counter run state (IDLE / RUN)
//   BCD_MAX   : largest legal BCD digit
//   bcd_step  : one up/down step of a BCD digit, returns {wrap, next_digit}
package bcd_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Up: 9 -> 0 wraps. Down: 0 -> 9 wraps.
    // Out-of-range inputs are treated as 9 going up so the result stays in 0-9.
    function automatic logic [4:0] bcd_step(input logic [3:0] digit, input logic up);
        logic [4:0] res;
        res = '0;
        if (up) begin
            if (digit >= BCD_MAX) res = {1'b1, 4'd0};
            else                  res = {1'b0, digit + 4'd1};
        end else begin
            if (digit == 4'd0)    res = {1'b1, BCD_MAX};
            else if (digit > BCD_MAX) res = {1'b0, BCD_MAX};
            else                  res = {1'b0, digit - 4'd1};
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_step_counter_tick_gen.sv
// Step prescaler for the BCD step counter.
//   clk  : rising-edge clock
//   rstn : synchronous active-low reset, clears the prescaler
//   run  : advance the prescaler this cycle
//   clr  : force the prescaler to 0 (wins over run)
//   tick : high on the cycle the prescaler sits at TICK_DIV-1 while running
module tick_gen #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TC = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    // Terminal count is combinational so the step lands on the same edge
    // that returns the prescaler to 0.
    assign tick = run && (cnt == TC);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run) begin
            if (cnt == TC) cnt <= '0;
            else           cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bcd_step_counter.sv
// Single-digit BCD up/down counter feeding a 4-to-10 one-hot decoder.
//   clk      : rising-edge clock
//   rstn     : synchronous active-low reset
//   start    : IDLE -> RUN request (level)
//   stop     : RUN -> IDLE request (level), wins over start
//   up_dn    : 1 = count up, 0 = count down
//   load     : parallel-load request
//   load_val : value to load, legal 0-9
//   digit    : current BCD digit, always 0-9
//   digit_en : high while running
//   carry    : one-cycle pulse on a 9->0 or 0->9 wrap
//   load_err : one-cycle pulse when a load asks for a value above 9
module bcd_step_counter
    import bcd_pkg::*;
#(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic       stop,
    input  logic       up_dn,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] digit,
    output logic       digit_en,
    output logic       carry,
    output logic       load_err
);

    state_t     state;
    logic       run;
    logic       go;
    logic       load_ok;
    logic       tick;
    logic [4:0] step_res;

    // Stop is applied before the prescaler sees the cycle, so a stop on the
    // terminal count suppresses the step and freezes the prescaler.
    assign run      = (state == RUN) && !stop;
    assign go       = (state == IDLE) && start && !stop;
    assign load_ok  = load && (load_val <= BCD_MAX);
    assign step_res = bcd_step(digit, up_dn);

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rstn (rstn),
        .run  (run),
        .clr  (go || load_ok),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            digit    <= '0;
            digit_en <= 1'b0;
            carry    <= 1'b0;
            load_err <= 1'b0;
        end else begin
            carry    <= 1'b0;
            load_err <= load && !load_ok;

            case (state)
                IDLE: begin
                    if (go) begin
                        state    <= RUN;
                        digit_en <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state    <= IDLE;
                        digit_en <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    digit_en <= 1'b0;
                end
            endcase

            // A valid load overrides a coincident step; a rejected load does not.
            if (load_ok) begin
                digit <= load_val;
            end else if (tick) begin
                digit <= step_res[3:0];
                carry <= step_res[4];
            end
        end
    end

endmodule

// File: tb/tb_bcd_step_counter.sv
// Directed self-checking bench for bcd_step_counter.
// Instance a uses TICK_DIV=4, instance b uses TICK_DIV=1.
module tb_bcd_step_counter;

    logic       clk;
    logic       rstn_a, start_a, stop_a, up_dn_a, load_a;
    logic [3:0] load_val_a, digit_a;
    logic       digit_en_a, carry_a, load_err_a;
    logic       rstn_b, start_b, stop_b, up_dn_b, load_b;
    logic [3:0] load_val_b, digit_b;
    logic       digit_en_b, carry_b, load_err_b;

    int unsigned n_cmp;
    int unsigned n_err;

    bcd_step_counter #(.TICK_DIV(4)) dut_a (
        .clk(clk), .rstn(rstn_a), .start(start_a), .stop(stop_a),
        .up_dn(up_dn_a), .load(load_a), .load_val(load_val_a),
        .digit(digit_a), .digit_en(digit_en_a), .carry(carry_a),
        .load_err(load_err_a)
    );

    bcd_step_counter #(.TICK_DIV(1)) dut_b (
        .clk(clk), .rstn(rstn_b), .start(start_b), .stop(stop_b),
        .up_dn(up_dn_b), .load(load_b), .load_val(load_val_b),
        .digit(digit_b), .digit_en(digit_en_b), .carry(carry_b),
        .load_err(load_err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [3:0] d, input logic en,
                         input logic c, input logic le);
        chk({tag, ".digit"},    digit_a,    d);
        chk({tag, ".digit_en"}, {3'b0, digit_en_a}, {3'b0, en});
        chk({tag, ".carry"},    {3'b0, carry_a},    {3'b0, c});
        chk({tag, ".load_err"}, {3'b0, load_err_a}, {3'b0, le});
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rstn_a = 1'b0; start_a = 1'b1; stop_a = 1'b0; up_dn_a = 1'b1;
        load_a = 1'b0; load_val_a = 4'd0;
        rstn_b = 1'b0; start_b = 1'b0; stop_b = 1'b0; up_dn_b = 1'b1;
        load_b = 1'b0; load_val_b = 4'd0;

        // Reset held 3 cycles with start asserted
        cyc(3);
        chk_a("reset", 4'd0, 1'b0, 1'b0, 1'b0);

        // Release: start sampled at next edge, first step 4 edges later
        rstn_a = 1'b1;
        cyc(1);
        chk_a("start", 4'd0, 1'b1, 1'b0, 1'b0);
        cyc(3);
        chk_a("pre_step", 4'd0, 1'b1, 1'b0, 1'b0);
        cyc(1);
        chk_a("first_step", 4'd1, 1'b1, 1'b0, 1'b0);
        start_a = 1'b0;

        // Up wrap: load 8, then 9, then 0 with carry
        load_a = 1'b1; load_val_a = 4'd8; up_dn_a = 1'b1;
        cyc(1);
        load_a = 1'b0;
        chk_a("up_load8", 4'd8, 1'b1, 1'b0, 1'b0);
        cyc(3);
        chk("up_hold8", digit_a, 4'd8);
        cyc(1);
        chk_a("up_to9", 4'd9, 1'b1, 1'b0, 1'b0);
        cyc(4);
        chk_a("up_wrap0", 4'd0, 1'b1, 1'b1, 1'b0);
        cyc(1);
        chk_a("up_after", 4'd0, 1'b1, 1'b0, 1'b0);

        // Down wrap: load 1, then 0, then 9 with carry
        load_a = 1'b1; load_val_a = 4'd1; up_dn_a = 1'b0;
        cyc(1);
        load_a = 1'b0;
        chk_a("dn_load1", 4'd1, 1'b1, 1'b0, 1'b0);
        cyc(4);
        chk_a("dn_to0", 4'd0, 1'b1, 1'b0, 1'b0);
        cyc(4);
        chk_a("dn_wrap9", 4'd9, 1'b1, 1'b1, 1'b0);
        cyc(1);
        chk_a("dn_after", 4'd9, 1'b1, 1'b0, 1'b0);

        // Invalid load: digit holds at 5, load_err pulses once
        load_a = 1'b1; load_val_a = 4'd5;
        cyc(1);
        chk("load5", digit_a, 4'd5);
        load_val_a = 4'd12;
        cyc(1);
        load_a = 1'b0;
        chk_a("bad_load", 4'd5, 1'b1, 1'b0, 1'b1);
        cyc(1);
        chk_a("bad_after", 4'd5, 1'b1, 1'b0, 1'b0);
        load_a = 1'b1; load_val_a = 4'd7;
        cyc(1);
        load_a = 1'b0;
        chk_a("load7", 4'd7, 1'b1, 1'b0, 1'b0);

        // Stop on the terminal-count cycle: no step, no carry
        up_dn_a = 1'b1;
        cyc(3);
        stop_a = 1'b1;
        cyc(1);
        stop_a = 1'b0;
        chk_a("stop_tc", 4'd7, 1'b0, 1'b0, 1'b0);
        cyc(4);
        chk("idle_frozen", digit_a, 4'd7);
        start_a = 1'b1;
        cyc(1);
        start_a = 1'b0;
        chk_a("restart", 4'd7, 1'b1, 1'b0, 1'b0);
        cyc(4);
        chk("restart_step", digit_a, 4'd8);

        // Valid load on a step cycle wins; next step 4 edges later
        cyc(3);
        load_a = 1'b1; load_val_a = 4'd2;
        cyc(1);
        load_a = 1'b0;
        chk_a("load_on_tc", 4'd2, 1'b1, 1'b0, 1'b0);
        cyc(3);
        chk("load_tc_hold", digit_a, 4'd2);
        cyc(1);
        chk("load_tc_step", digit_a, 4'd3);

        // Invalid load on a step cycle: step still happens
        cyc(3);
        load_a = 1'b1; load_val_a = 4'd15;
        cyc(1);
        load_a = 1'b0;
        chk_a("bad_on_tc", 4'd4, 1'b1, 1'b0, 1'b1);

        // Start with stop while idle: remain idle
        stop_a = 1'b1;
        cyc(1);
        start_a = 1'b1;
        cyc(1);
        start_a = 1'b0; stop_a = 1'b0;
        chk_a("start_stop_idle", 4'd4, 1'b0, 1'b0, 1'b0);

        // TICK_DIV=1: step every cycle, one carry on 9->0
        rstn_b = 1'b1; start_b = 1'b1; up_dn_b = 1'b1;
        cyc(1);
        start_b = 1'b0;
        chk("b_start_digit", digit_b, 4'd0);
        chk("b_start_en", {3'b0, digit_en_b}, 4'd1);
        for (int unsigned i = 1; i <= 10; i++) begin
            cyc(1);
            chk("b_digit", digit_b, 4'(i % 10));
            chk("b_carry", {3'b0, carry_b}, (i == 10) ? 4'd1 : 4'd0);
        end
        cyc(4);
        chk("b_run_more", digit_b, 4'd4);

        // Mid-run reset clears everything on that edge
        rstn_b = 1'b0; start_b = 1'b1;
        cyc(1);
        chk("b_rst_digit", digit_b, 4'd0);
        chk("b_rst_en", {3'b0, digit_en_b}, 4'd0);
        chk("b_rst_carry", {3'b0, carry_b}, 4'd0);
        chk("b_rst_lerr", {3'b0, load_err_b}, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bcd_step_counter.md
# bcd_step_counter

Single-digit BCD up/down counter that generates the 4-bit digit and enable consumed by the 4-to-10 one-hot decoder directly downstream. The counter steps once every TICK_DIV clocks while running. It supports parallel load with range checking and pulses a carry/borrow on wrap-around. It is the digit source for the decimal display/indicator chain.

## Interface
- TICK_DIV, default 4: clocks per count step; legal range ≥1.
- clk  input  1  rising-edge clock.
- rstn  input  1  reset; synchronous, active-low.
- start  input  1  level, sampled each edge; IDLE→RUN.
- stop  input  1  level; RUN→IDLE; wins over start.
- up_dn  input  1  1 = count up, 0 = count down; sampled on step cycle.
- load  input  1  parallel-load request.
- load_val  input  4  value to load; legal 0–9.
- digit  output  4  current BCD digit (to decoder din); always 0–9.
- digit_en  output  1  1 while state is RUN (to decoder en).
- carry  output  1  one-cycle pulse on 9→0 (up) or 0→9 (down) wrap.
- load_err  output  1  one-cycle pulse when load is requested with load_val > 9.

## Operation
- States: IDLE, RUN. All outputs are registered.
- Reset (rstn=0 at an edge):
  - state = IDLE, prescaler = 0, digit = 0.
  - digit_en = 0, carry = 0, load_err = 0.
  - Reset overrides every other input.
- Transitions:
  - IDLE + start & !stop → RUN, prescaler cleared to 0.
  - RUN + stop → IDLE; prescaler holds its value and is cleared on the next start.
  - start while in RUN is ignored; it does not clear the prescaler.
- Prescaler (RUN only):
  - Counts 0..TICK_DIV-1. On the edge where it equals TICK_DIV-1, it returns to 0 and the digit steps.
  - With TICK_DIV=1, the digit steps every cycle.
- Step:
  - Up: digit+1. 9→0 sets carry=1 for that cycle.
  - Down: digit-1. 0→9 sets carry=1.
  - carry=0 on all other cycles.
- Load (any state):
  - If load_val ≤ 9: digit = load_val, prescaler cleared, no carry. Load overrides a step falling in the same cycle.
  - If load_val > 9: digit and prescaler are unchanged, load_err=1 for one cycle, and any coincident step proceeds normally.
- Simultaneous events:
  - stop together with a prescaler terminal count: stop wins, no step, no carry.
  - load together with stop: both take effect.
  - start together with stop in IDLE: remain IDLE.
- digit never leaves 0–9 under any input sequence.

## Timing
- start sampled at edge k → digit_en=1 after edge k; first step at edge k+TICK_DIV. Subsequent steps every TICK_DIV edges.
- stop sampled at edge k → digit_en=0 after edge k; digit frozen from edge k.
- Valid load at edge k → digit=load_val after edge k; next step at edge k+TICK_DIV if running.
- carry and load_err are registered, high exactly one cycle, aligned with the new digit value.
- Latency from digit to decoder output is set by the decoder (combinational); no handshake is needed.

## Structure
- Package bcd_pkg:
  - state_t enum {IDLE, RUN}.
  - BCD_MAX = 4'd9.
  - Function bcd_step(digit, up) returning {wrap, next_digit}.
- Sub-module tick_gen: parameterised TICK_DIV prescaler, width $clog2(TICK_DIV) (min 1).
  - Inputs: clk, rstn, run, clr.
  - Output: tick.
- The top level holds the FSM, digit register, load logic and pulse outputs.

## Test plan
- Reset, TICK_DIV=4: hold rstn=0 3 cycles with start=1 → digit=0, digit_en=0, carry=0, load_err=0. After release with start=1, first step at the 4th edge → digit=1.
- Up wrap: load 8, run up 2 steps → digit 9 then 0; carry=1 only in the cycle digit=0.
- Down wrap: load 1, up_dn=0, 2 steps → digit 0 then 9; carry=1 only with digit=9.
- Invalid load: load_val=12 while digit=5 → digit stays 5, load_err pulses 1 cycle. Then load_val=7 → digit=7, load_err=0.
- Collisions:
  - stop on a terminal-count cycle → no step.
  - valid load on a step cycle → digit=load_val and the next step is 4 cycles later.
- TICK_DIV=1 and mid-run reset: step every cycle, 10 steps up from 0 → carry once at 9→0. Assert rstn=0 mid-run → all outputs reset on that edge.
